// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit feeder: FSM encodings, FIFO depth, byte width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam int UART_DEFAULT_FIFO_DEPTH = 16;
  localparam int UART_BYTE_W             = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/sync_fifo_8.sv
// Single-clock byte FIFO with registered full/empty/count flags derived from the count.
// Latency: a pushed byte is visible at pop_data one edge after the push (no bypass).
// Backpressure: pushes while full and pops while empty are ignored; the caller owns overflow reporting.
module sync_fifo_8
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              push,
  input  uart_byte_t        push_data,
  input  logic              pop,
  output uart_byte_t        pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  uart_byte_t        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;
  logic [ADDR_W:0]   count_nxt;

  // Qualify requests against the flags as they stood before the edge.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents need no reset since the flags gate every read.
  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; flags registered from the next count.
  always_ff @(posedge i_Clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers CPU byte writes and feeds them one at a time to the UART transmitter's DV/Done level handshake.
// Latency: write at edge N into an idle, empty block raises o_tx_dv after edge N+1.
// Backpressure: writes while full are dropped and flagged in sticky o_overflow; draining waits on Done rise then fall.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              i_wr,
  input  logic [7:0]        i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  input  logic              i_clr_overflow,
  output logic              o_busy,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_done
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pop;
  uart_byte_t fifo_dat;

  sync_fifo_8 #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .reset     (reset),
    .push      (i_wr),
    .push_data (i_wr_data),
    .pop       (pop),
    .pop_data  (fifo_dat),
    .full      (o_full),
    .empty     (o_empty),
    .count     (o_count)
  );

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_Clock) begin
    if (!reset) begin
      o_overflow <= 1'b0;
    end else if (i_wr && o_full) begin
      o_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_overflow <= 1'b0;
    end
  end

  // Handshake state register.
  always_ff @(posedge i_Clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: RELEASE waits for Done to fall so a stale Done cannot retire the next byte.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = o_empty   ? S_IDLE  : S_ASSERT;
      S_ASSERT:  state_nxt = i_tx_done ? S_RELEASE : S_ASSERT;
      S_RELEASE: state_nxt = i_tx_done ? S_RELEASE : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Pop strobe: only on the IDLE->ASSERT transition.
  always_comb begin
    pop = (state == S_IDLE) && !o_empty;
  end

  // Registered transmitter outputs; the byte only loads on pop, so it is stable for the whole DV window.
  always_ff @(posedge i_Clock) begin
    if (!reset) begin
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
    end else begin
      o_tx_dv <= (state_nxt == S_ASSERT);
      if (pop) o_tx_byte <= fifo_dat;
    end
  end

  assign o_busy = !o_empty || (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a transmitter model doubles as the output monitor and scoreboard.
// Latency: bench drives inputs and samples flags 2 time units after each posedge; the model acts on negedges.
// Backpressure: the model can stall Done indefinitely or hold it stale after DV falls.
module tb_uart_tx_feeder;

  logic       i_Clock = 1'b0;
  logic       reset;
  logic       i_wr;
  logic [7:0] i_wr_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       i_clr_overflow;
  logic       o_busy;
  logic       o_tx_dv;
  logic [7:0] o_tx_byte;
  logic       i_tx_done;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] exp_q [$];

  // Transmitter model controls
  int done_delay  = 3;
  bit stall       = 1'b0;
  int stale_extra = 0;
  bit model_rst   = 1'b0;
  int pulses      = 0;
  int mstate      = 0;

  always #5 i_Clock = ~i_Clock;

  uart_tx_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_Clock        (i_Clock),
    .reset          (reset),
    .i_wr           (i_wr),
    .i_wr_data      (i_wr_data),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .i_clr_overflow (i_clr_overflow),
    .o_busy         (o_busy),
    .o_tx_dv        (o_tx_dv),
    .o_tx_byte      (o_tx_byte),
    .i_tx_done      (i_tx_done)
  );

  // Transmitter model and monitor: captures each DV rise, checks it against the scoreboard,
  // checks the byte is held, raises Done after a delay and drops it after DV falls.
  initial begin
    logic [7:0] cap;
    logic [7:0] exp_b;
    int         cnt;
    bit         hold_bad;
    bit         first;
    cap = 8'h00; cnt = 0; hold_bad = 1'b0; first = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (model_rst) begin
        mstate    = 0;
        i_tx_done = 1'b0;
      end else begin
        case (mstate)
          0: if (o_tx_dv === 1'b1) begin
               pulses++;
               vectors++;
               if (exp_q.size() == 0) begin
                 errors++;
                 $display("FAIL unexpected_dv: got byte %02h, wanted no DV", o_tx_byte);
               end else begin
                 exp_b = exp_q.pop_front();
                 if (o_tx_byte !== exp_b) begin
                   errors++;
                   $display("FAIL tx_byte: got %02h want %02h", o_tx_byte, exp_b);
                 end
               end
               cap      = o_tx_byte;
               cnt      = done_delay;
               hold_bad = 1'b0;
               mstate   = 1;
             end
          1: begin
               if (o_tx_dv !== 1'b1 || o_tx_byte !== cap) hold_bad = 1'b1;
               if (!stall) begin
                 if (cnt > 1) cnt--;
                 else begin
                   i_tx_done = 1'b1;
                   vectors++;
                   if (hold_bad) begin
                     errors++;
                     $display("FAIL dv_hold: byte %02h dv/byte changed during transfer, want stable", cap);
                   end
                   first  = 1'b1;
                   mstate = 2;
                 end
               end
             end
          2: begin
               if (first) begin
                 vectors++;
                 if (o_tx_dv !== 1'b0) begin
                   errors++;
                   $display("FAIL dv_drop: dv=%b one cycle after Done, want 0", o_tx_dv);
                 end
                 first = 1'b0;
               end
               if (o_tx_dv === 1'b0) begin
                 if (stale_extra == 0) begin
                   i_tx_done = 1'b0;
                   mstate    = 0;
                 end else begin
                   cnt    = stale_extra;
                   mstate = 3;
                 end
               end
             end
          default: begin
               if (o_tx_dv === 1'b1) begin
                 vectors++;
                 errors++;
                 $display("FAIL dv_during_stale_done: dv=1 want 0");
               end
               cnt--;
               if (cnt <= 0) begin
                 i_tx_done = 1'b0;
                 mstate    = 0;
               end
             end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge i_Clock);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit keep);
    i_wr      = 1'b1;
    i_wr_data = b;
    if (keep) exp_q.push_back(b);
    tick();
    i_wr = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((o_busy || exp_q.size() != 0 || mstate != 0) && n < maxc) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, want idle", n);
    end
  endtask

  initial begin
    int p0;
    reset          = 1'b0;
    i_wr           = 1'b1;
    i_wr_data      = 8'hAA;
    i_clr_overflow = 1'b0;

    // Reset with writes attempted
    repeat (3) tick();
    reset = 1'b1;
    i_wr  = 1'b0;
    check("rst_empty",    32'(o_empty),    32'd1);
    check("rst_full",     32'(o_full),     32'd0);
    check("rst_count",    32'(o_count),    32'd0);
    check("rst_dv",       32'(o_tx_dv),    32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    check("rst_busy",     32'(o_busy),     32'd0);
    check("rst_byte",     32'(o_tx_byte),  32'h00);
    tick();

    // Single byte with a realistic bit-time Done delay
    done_delay = 4340;
    wr(8'h41, 1'b1);
    check("single_count_after_wr", 32'(o_count), 32'd1);
    check("single_dv_not_yet",     32'(o_tx_dv), 32'd0);
    tick();
    check("single_dv",    32'(o_tx_dv),   32'd1);
    check("single_byte",  32'(o_tx_byte), 32'h41);
    check("single_count", 32'(o_count),   32'd0);
    check("single_busy",  32'(o_busy),    32'd1);
    wait_idle(5000);
    check("single_idle_busy", 32'(o_busy),  32'd0);
    check("single_idle_dv",   32'(o_tx_dv), 32'd0);
    done_delay = 3;

    // Burst of 16 consecutive bytes
    p0 = pulses;
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1);
    check("burst_overflow", 32'(o_overflow), 32'd0);
    wait_idle(1000);
    check("burst_pulses", 32'(pulses - p0), 32'd16);

    // Overflow with a stalled transmitter: 0x20 popped, 0x21..0x30 fill, 0x31 dropped
    stall = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 18; i++) wr(8'(8'h20 + i), i < 17);
    check("ovf_count",    32'(o_count),    32'd16);
    check("ovf_full",     32'(o_full),     32'd1);
    check("ovf_flag",     32'(o_overflow), 32'd1);
    check("ovf_dv",       32'(o_tx_dv),    32'd1);
    check("ovf_byte",     32'(o_tx_byte),  32'h20);
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    check("ovf_clr", 32'(o_overflow), 32'd0);
    i_wr           = 1'b1;
    i_wr_data      = 8'h77;
    i_clr_overflow = 1'b1;
    tick();
    i_wr           = 1'b0;
    i_clr_overflow = 1'b0;
    check("ovf_set_wins",  32'(o_overflow), 32'd1);
    check("ovf_count_hold", 32'(o_count),   32'd16);
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    stall = 1'b0;
    wait_idle(2000);
    check("ovf_pulses", 32'(pulses - p0), 32'd17);

    // Stale Done held two cycles after DV falls
    stale_extra = 2;
    p0 = pulses;
    wr(8'h61, 1'b1);
    wr(8'h62, 1'b1);
    wait_idle(500);
    check("stale_pulses", 32'(pulses - p0), 32'd2);
    stale_extra = 0;

    // Reset in the middle of a transfer with 3 bytes queued
    stall = 1'b1;
    wr(8'h81, 1'b1);
    wr(8'h82, 1'b1);
    wr(8'h83, 1'b1);
    wr(8'h84, 1'b1);
    check("midrst_pre_dv",    32'(o_tx_dv), 32'd1);
    check("midrst_pre_count", 32'(o_count), 32'd3);
    reset     = 1'b0;
    model_rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_dv",    32'(o_tx_dv), 32'd0);
    check("midrst_count", 32'(o_count), 32'd0);
    check("midrst_empty", 32'(o_empty), 32'd1);
    check("midrst_busy",  32'(o_busy),  32'd0);
    reset = 1'b1;
    stall = 1'b0;
    tick();
    model_rst = 1'b0;
    wr(8'h55, 1'b1);
    tick();
    check("post_rst_dv",   32'(o_tx_dv),   32'd1);
    check("post_rst_byte", 32'(o_tx_byte), 32'h55);
    wait_idle(500);
    check("post_rst_busy", 32'(o_busy), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
